fetch_stall_ctrl: RTL and testbench
===================================

# fetch_stall_ctrl

Instruction-fetch controller that consumes the pipeline's `stall` / `stall_pm` handshake. It drives the program-memory read port, advances the program counter and loads the IF/ID instruction register. It freezes, bubbles, redirects and halts in response to those stall signals, a jump redirect and a decoded HALT opcode. It sits between program memory and the decode stage, downstream of the stall-control logic that generates `stall` / `stall_pm`.

## Interface
- `ADDR_W`, 8: program-memory word-address width.
- `DATA_W`, 32: instruction width; opcode is bits [DATA_W-1:DATA_W-6].
- `RESET_PC`, 0: first fetch address after reset.
- `NOP`, 32'h0000_0000: bubble instruction.
- `HALT_OP`, 6'b010001: opcode that stops fetch.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high; all state is reset on a rising edge while high.
- `stall`  in  1  squash: the instruction being loaded this edge becomes `NOP`; PC still advances.
- `stall_pm`  in  1  freeze: no fetch issued; `pc`, `ir`, `ir_valid` and `ir_pc` hold.
- `redirect`  in  1  jump taken this cycle.
- `redirect_addr`  in  ADDR_W  jump target.
- `pm_addr`  out  ADDR_W  read address; always equals `pc`.
- `pm_rd`  out  1  read strobe; memory returns data one cycle later.
- `pm_data`  in  DATA_W  read data, valid the cycle after `pm_rd`.
- `ir`  out  DATA_W  IF/ID instruction register.
- `ir_valid`  out  1  `ir` holds a real (non-bubble) instruction.
- `ir_pc`  out  ADDR_W  address of the instruction in `ir`.
- `halted`  out  1  HALT reached; fetch stopped.

## Operation
- State machine: RUN and HALTED. Reset enters RUN. RUN goes to HALTED when an instruction with opcode == HALT_OP is loaded into `ir` with `ir_valid`=1. HALTED is left only by `reset`.
- `pm_rd` = RUN & !reset & !stall_pm & !redirect. This is combinational.
- On an edge with `pm_rd`=1: `pc` <= `pc`+1 (mod 2^ADDR_W; 0xFF wraps to 0x00), `inflight` <= 1, `inflight_pc` <= `pc`.
- Response source for the next edge: the hold buffer if `hbuf_vld` is set, else `pm_data` if `inflight` is set.
- Priority at each edge: reset > redirect > stall_pm > stall > normal.
  - redirect: `pc` <= `redirect_addr`; `inflight`, `hbuf_vld` <= 0 (discarded); `ir` <= NOP, `ir_valid` <= 0. Applies even while `stall_pm`=1.
  - stall_pm=1: `ir`, `ir_valid`, `ir_pc` and `pc` hold. A response arriving this cycle is copied into the hold buffer (data + pc, `hbuf_vld` <= 1). At most one entry is ever needed; an overflow is impossible by construction and an assertion checks it.
  - stall=1, stall_pm=0: the source is consumed; `ir` <= NOP, `ir_valid` <= 0, `ir_pc` <= source pc. The HALT check is not applied to a squashed instruction.
  - normal: `ir` <= source data, `ir_valid` <= 1, `ir_pc` <= source pc; the buffer is cleared if used. With no source: `ir` <= NOP, `ir_valid` <= 0.
- Entering HALTED: `pm_rd`=0, any in-flight response is discarded, and `ir` holds the HALT instruction with `ir_valid`=1 for exactly one cycle, then NOP with `ir_valid`=0. `halted`=1 from the cycle after the HALT is loaded.

## Timing
- Reset values: `pc`=RESET_PC, `ir`=NOP, `ir_valid`=0, `ir_pc`=0, `halted`=0, `inflight`=0, `hbuf_vld`=0. `pm_rd`=0 while `reset`=1.
- Latency: address A is presented with `pm_rd` in cycle N, `pm_data` is valid in N+1, and `ir`=mem[A] is visible in N+2. Sustained throughput is one instruction per cycle.
- `stall_pm` high for k cycles: `ir` is frozen for k cycles. The buffered response appears in `ir` on the first edge after `stall_pm` falls, with no gap and no duplicate.
- Redirect in cycle N: the first target fetch is issued in N+1, and the target instruction reaches `ir` in N+3. `ir_valid`=0 for the intervening cycles.
- Reset mid-stream clears everything on the same edge; the next fetch is RESET_PC.

## Test plan
- Reset then free run, mem[i]=i+0x100: `ir` = 0x100, 0x101, 0x102… starting 2 cycles after reset deasserts, `ir_pc` = 0, 1, 2…, `ir_valid`=1 continuously.
- `stall_pm` high for 3 cycles mid-stream while fetching address 5: `ir` holds mem[4] for 3 cycles, then shows mem[5], then mem[6]; no instruction is lost or duplicated and `pm_rd`=0 for exactly 3 cycles.
- `stall`=1 for 2 cycles: two consecutive `ir` values are NOP with `ir_valid`=0 and `ir_pc` = the squashed addresses; the stream resumes at the following address.
- `redirect`=1 with `redirect_addr`=0x40 while sequential fetch is at 0x0A: the in-flight instruction is dropped, `ir_valid`=0 for 2 cycles, then `ir`=mem[0x40] with `ir_pc`=0x40. Repeat with `stall_pm`=1 at the same time: the result is identical.
- Place HALT_OP at address 3: `ir`=HALT for one cycle, `halted`=1 thereafter, `pm_rd` stays 0 and `ir_valid`=0. Asserting `reset` restarts at RESET_PC with `halted`=0.
- `RESET_PC`=0xFE, run 4 fetches: `pm_addr` = 0xFE, 0xFF, 0x00, 0x01 (wrap).

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - instruction fetch controller with freeze/squash/redirect/halt handling
// Drives program memory, tracks the one outstanding read and loads the IF/ID register.
module fetch_stall_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP      = '0,
  parameter logic [5:0]        HALT_OP  = 6'b010001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              stall_pm,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_rd,
  input  logic [DATA_W-1:0] pm_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              halted
);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                inflight;
  logic [ADDR_W-1:0]   inflight_pc;
  logic                hbuf_vld;
  logic [DATA_W-1:0]   hbuf_data;
  logic [ADDR_W-1:0]   hbuf_pc;

  logic                src_vld;
  logic [DATA_W-1:0]   src_data;
  logic [ADDR_W-1:0]   src_pc;
  logic                src_is_halt;

  assign pm_addr = pc;
  assign pm_rd   = (state == ST_RUN) && !reset && !stall_pm && !redirect;

  // The hold buffer is older than anything arriving on pm_data, so it wins.
  assign src_vld     = hbuf_vld || inflight;
  assign src_data    = hbuf_vld ? hbuf_data : pm_data;
  assign src_pc      = hbuf_vld ? hbuf_pc : inflight_pc;
  assign src_is_halt = (src_data[DATA_W-1 -: 6] == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      hbuf_vld    <= 1'b0;
      hbuf_data   <= '0;
      hbuf_pc     <= '0;
      ir          <= NOP;
      ir_valid    <= 1'b0;
      ir_pc       <= '0;
      halted      <= 1'b0;
    end else if (state == ST_HALTED) begin
      ir       <= NOP;
      ir_valid <= 1'b0;
      inflight <= 1'b0;
      hbuf_vld <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_addr;
      inflight <= 1'b0;
      hbuf_vld <= 1'b0;
      ir       <= NOP;
      ir_valid <= 1'b0;
    end else if (stall_pm) begin
      // Park a response that lands while frozen; no new fetch is issued.
      if (inflight && !hbuf_vld) begin
        hbuf_vld  <= 1'b1;
        hbuf_data <= pm_data;
        hbuf_pc   <= inflight_pc;
      end
      inflight <= 1'b0;
    end else begin
      pc          <= pc + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= pc;
      if (src_vld) begin
        ir_pc    <= src_pc;
        hbuf_vld <= 1'b0;
      end
      if (stall || !src_vld) begin
        ir       <= NOP;
        ir_valid <= 1'b0;
      end else begin
        ir       <= src_data;
        ir_valid <= 1'b1;
        if (src_is_halt) begin
          state    <= ST_HALTED;
          halted   <= 1'b1;
          inflight <= 1'b0;
        end
      end
    end
  end

  hbuf_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(stall_pm && !redirect && hbuf_vld && inflight));

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - scoreboard bench for fetch_stall_ctrl
module tb_fetch_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        stall_pm = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic [7:0]  pm_addr;
  logic        pm_rd;
  logic [31:0] pm_data = 32'h0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [7:0]  ir_pc;
  logic        halted;

  logic [7:0]  pm_addr2;
  logic        pm_rd2;
  logic [31:0] pm_data2 = 32'h0;
  logic [31:0] ir2;
  logic        ir_valid2;
  logic [7:0]  ir_pc2;
  logic        halted2;

  localparam logic [31:0] HALT_INSN = 32'h4400_0000;

  logic [31:0] mem [256];

  typedef struct {
    logic        v;
    logic        chk_pc;
    logic [31:0] d;
    logic [7:0]  pc;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;

  fetch_stall_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data),
    .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc), .halted(halted)
  );

  fetch_stall_ctrl #(.RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .pm_addr(pm_addr2), .pm_rd(pm_rd2), .pm_data(pm_data2),
    .ir(ir2), .ir_valid(ir_valid2), .ir_pc(ir_pc2), .halted(halted2)
  );

  always #5 clk = ~clk;

  // Synchronous program memory; garbage when not read so stale data is noticed.
  always @(posedge clk) begin
    if (pm_rd) pm_data <= mem[pm_addr];
    else       pm_data <= 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string name);
    return $sformatf("%s@c%0d", name, cyc);
  endfunction

  task automatic push_v(input int a);
    sb_t e;
    e.v = 1'b1; e.chk_pc = 1'b1; e.d = mem[a]; e.pc = 8'(a);
    sb_q.push_back(e);
  endtask

  task automatic push_inv(input logic chk, input int a);
    sb_t e;
    e.v = 1'b0; e.chk_pc = chk; e.d = 32'h0; e.pc = 8'(a);
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check_eq(tg("sb_depth"), 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(tg("ir_valid"), ir_valid, e.v);
      check_eq(tg("ir"), ir, e.d);
      if (e.chk_pc) check_eq(tg("ir_pc"), ir_pc, e.pc);
    end
  endtask

  task automatic run_cycle(input logic s, input logic spm, input logic rd, input logic [7:0] ra);
    @(posedge clk); #1;
    reset = 1'b0; stall = s; stall_pm = spm; redirect = rd; redirect_addr = ra;
    @(negedge clk);
    sb_check();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check_eq("rst_pm_rd_comb", pm_rd, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_ir_valid", ir_valid, 1'b0);
    check_eq("rst_ir_pc", ir_pc, 8'h00);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_pm_addr", pm_addr, 8'h00);
    check_eq("rst_pm_rd", pm_rd, 1'b0);
    check_eq("rst_pm_addr_wrap", pm_addr2, 8'hFE);
    cyc = -1;
  endtask

  initial begin
    logic [7:0] wrap_exp [4];
    int         exp_pc;
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;

    // Free run, then freeze while address 5 is in flight, then a two-cycle squash.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if (k < 2)                 push_inv(1'b0, 0);
      else if (k <= 6)           push_v(k - 2);
      else if (k <= 9)           push_v(4);
      else if (k == 14 || k == 15) push_inv(1'b1, k - 5);
      else                       push_v(k - 5);
    end
    for (int k = 0; k < 18; k++) begin
      cyc = k;
      run_cycle(k == 13 || k == 14, k >= 6 && k <= 8, 1'b0, 8'h00);
      check_eq(tg("pm_rd"), pm_rd, !(k >= 6 && k <= 8));
      exp_pc = (k <= 6) ? k : (k <= 9 ? 6 : k - 3);
      check_eq(tg("pm_addr"), pm_addr, 8'(exp_pc));
      if (k < 4) begin
        check_eq(tg("wrap_pm_addr"), pm_addr2, wrap_exp[k]);
        check_eq(tg("wrap_pm_rd"), pm_rd2, 1'b1);
      end
    end

    // Redirect to 0x40 while fetching 0x0A, alone and together with stall_pm.
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      for (int k = 0; k < 15; k++) begin
        if (k < 2)                   push_inv(1'b0, 0);
        else if (k <= 10)            push_v(k - 2);
        else if (k <= 12)            push_inv(1'b0, 0);
        else                         push_v(8'h40 + k - 13);
      end
      for (int k = 0; k < 15; k++) begin
        cyc = 100 * (rep + 1) + k;
        run_cycle(1'b0, rep == 1 && k == 10, k == 10, 8'h40);
        if (k == 10) begin
          check_eq(tg("redir_pm_addr"), pm_addr, 8'h0A);
          check_eq(tg("redir_pm_rd"), pm_rd, 1'b0);
        end
        if (k == 11) begin
          check_eq(tg("target_pm_addr"), pm_addr, 8'h40);
          check_eq(tg("target_pm_rd"), pm_rd, 1'b1);
        end
      end
    end

    // HALT at address 3, then reset restarts from RESET_PC.
    mem[3] = HALT_INSN;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 2)       push_inv(1'b0, 0);
      else if (k <= 5) push_v(k - 2);
      else             push_inv(1'b0, 0);
    end
    for (int k = 0; k < 10; k++) begin
      cyc = 300 + k;
      run_cycle(1'b0, 1'b0, 1'b0, 8'h00);
      if (k == 4) check_eq(tg("halted_early"), halted, 1'b0);
      if (k >= 6) check_eq(tg("halted"), halted, 1'b1);
      if (k >= 5) check_eq(tg("halt_pm_rd"), pm_rd, 1'b0);
    end
    mem[3] = 32'h103;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k < 2) push_inv(1'b0, 0);
      else       push_v(k - 2);
    end
    for (int k = 0; k < 4; k++) begin
      cyc = 400 + k;
      run_cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq(tg("restart_pm_addr"), pm_addr, 8'(k));
      check_eq(tg("restart_halted"), halted, 1'b0);
    end

    check_eq("sb_left", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
